// File: rtl/fb_arbiter.sv
// Frame-buffer SRAM arbiter: scan-out reads compete with a posted-write FIFO from the sprite engine.
// Optional build macro FB_ARB_RAW_CHECK_EN blocks reads that hit an address still posted in the FIFO.
module fb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [11:0] wr_addr,
  input  logic [11:0] wr_data,
  output logic        wr_ready,
  input  logic        rd_req,
  input  logic [11:0] rd_addr,
  output logic        rd_gnt,
  output logic        rd_valid,
  output logic [11:0] rd_data,
  input  logic        flush,
  output logic        flush_done,
  output logic        fifo_empty,
  output logic        FB_CEN,
  output logic        FB_WEN,
  output logic [11:0] FB_A,
  output logic [11:0] FB_D,
  input  logic [11:0] FB_Q
);

  localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          flush_blk_q, flush_blk_d;
  logic          fb_cen_q, fb_cen_d, fb_wen_q, fb_wen_d;
  logic [11:0]   fb_a_q, fb_a_d, fb_d_q, fb_d_d;
  logic          rd_valid_q, rd_valid_d;
  logic          flush_done_q, flush_done_d;
  logic [23:0]   mem_q [FIFO_DEPTH];

  logic          full_s, empty_s, push_s, pop_s, drain_s, done_s, raw_hit_s;
  logic [23:0]   head_s;

  assign full_s     = (count_q == DEPTH_C);
  assign empty_s    = (count_q == {CW{1'b0}});
  assign head_s     = mem_q[rptr_q];
  // A full FIFO still takes a push in a cycle where the head is popped.
  assign push_s     = wr_valid & (~full_s | pop_s);

  assign wr_ready   = ~full_s;
  assign fifo_empty = empty_s;
  assign FB_CEN     = fb_cen_q;
  assign FB_WEN     = fb_wen_q;
  assign FB_A       = fb_a_q;
  assign FB_D       = fb_d_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_valid_q ? FB_Q : 12'h000;
  assign flush_done = flush_done_q;

`ifdef FB_ARB_RAW_CHECK_EN
  logic [AW-1:0] raw_off_s;

  // Compare the read address against every occupied FIFO slot.
  always_comb begin
    raw_hit_s = 1'b0;
    raw_off_s = {AW{1'b0}};
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      raw_off_s = AW'(j) - rptr_q;
      if (({1'b0, raw_off_s} < count_q) && (mem_q[j][23:12] == rd_addr)) begin
        raw_hit_s = 1'b1;
      end else begin
        raw_hit_s = raw_hit_s;
      end
    end
  end
`else
  assign raw_hit_s = 1'b0;
`endif

  // Per-cycle access decision; the chosen access is registered onto the SRAM port.
  always_comb begin
    state_d  = IDLE;
    rd_gnt   = 1'b0;
    pop_s    = 1'b0;
    done_s   = 1'b0;
    fb_cen_d = 1'b1;
    fb_wen_d = 1'b1;
    fb_a_d   = fb_a_q;
    fb_d_d   = fb_d_q;
    drain_s  = (state_q == DRAIN) || (flush && !flush_blk_q);

    if (drain_s) begin
      if (!empty_s) begin
        pop_s   = 1'b1;
        state_d = DRAIN;
      end else if (wr_valid || (state_q != DRAIN)) begin
        state_d = DRAIN;
      end else begin
        done_s  = 1'b1;
        state_d = IDLE;
      end
    end else if (!empty_s && ((starve_q == SMAX_C) || full_s)) begin
      pop_s   = 1'b1;
      state_d = WRITE;
    end else if (rd_req && !raw_hit_s) begin
      rd_gnt  = 1'b1;
      state_d = READ;
    end else if (!empty_s) begin
      pop_s   = 1'b1;
      state_d = WRITE;
    end else begin
      state_d = IDLE;
    end

    if (pop_s) begin
      fb_cen_d = 1'b0;
      fb_wen_d = 1'b0;
      fb_a_d   = head_s[23:12];
      fb_d_d   = head_s[11:0];
    end else if (rd_gnt) begin
      fb_cen_d = 1'b0;
      fb_wen_d = 1'b1;
      fb_a_d   = rd_addr;
    end else begin
      fb_cen_d = 1'b1;
      fb_wen_d = 1'b1;
    end
  end

  // FIFO bookkeeping, starvation counter and flush re-entry guard.
  always_comb begin
    wptr_d       = push_s ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d       = pop_s ? (rptr_q + AW'(1)) : rptr_q;
    count_d      = count_q + CW'(push_s) - CW'(pop_s);
    flush_blk_d  = flush & (flush_blk_q | done_s);
    flush_done_d = done_s;
    rd_valid_d   = ~fb_cen_q & fb_wen_q;
    if (pop_s) begin
      starve_d = {SW{1'b0}};
    end else if (rd_gnt && !empty_s && (starve_q != SMAX_C)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wptr_q       <= {AW{1'b0}};
      rptr_q       <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      starve_q     <= {SW{1'b0}};
      flush_blk_q  <= 1'b0;
      fb_cen_q     <= 1'b1;
      fb_wen_q     <= 1'b1;
      fb_a_q       <= 12'h000;
      fb_d_q       <= 12'h000;
      rd_valid_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      flush_blk_q  <= flush_blk_d;
      fb_cen_q     <= fb_cen_d;
      fb_wen_q     <= fb_wen_d;
      fb_a_q       <= fb_a_d;
      fb_d_q       <= fb_d_d;
      rd_valid_q   <= rd_valid_d;
      flush_done_q <= flush_done_d;
    end
  end

  // FIFO storage; occupancy is tracked by the pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= {wr_addr, wr_data};
    end else begin
      mem_q[wptr_q] <= mem_q[wptr_q];
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural single-port SRAM on the FB_* port.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid, wr_ready, rd_req, rd_gnt, rd_valid, flush, flush_done, fifo_empty;
  logic [11:0] wr_addr, wr_data, rd_addr, rd_data;
  logic        FB_CEN, FB_WEN;
  logic [11:0] FB_A, FB_D, FB_Q;

  int n_checks = 0;
  int n_fail   = 0;

  fb_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .flush(flush), .flush_done(flush_done), .fifo_empty(fifo_empty),
    .FB_CEN(FB_CEN), .FB_WEN(FB_WEN), .FB_A(FB_A), .FB_D(FB_D), .FB_Q(FB_Q)
  );

  always #5 clk = ~clk;

  logic [11:0] sram [0:4095];
  logic [11:0] sram_q = 12'h000;
  logic [23:0] wlog [$];

  // Synchronous SRAM: data read at an access edge is presented on FB_Q the next cycle.
  always @(posedge clk) begin
    if (!FB_CEN) begin
      if (!FB_WEN) begin
        sram[FB_A] <= FB_D;
        wlog.push_back({FB_A, FB_D});
      end else begin
        sram_q <= sram[FB_A];
      end
    end
  end
  assign FB_Q = sram_q;

  typedef struct {
    logic wv; logic [11:0] wa; logic [11:0] wd; logic rr; logic [11:0] ra; logic fl;
    logic gnt; logic cen; logic wen; logic chkad; logic [11:0] a; logic [11:0] d;
    logic emp; logic rdy; logic rv; logic [11:0] rdata;
  } vec_t;

  vec_t tbl [10];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk12(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, " FB_CEN"}, FB_CEN, 1'b1);
    chk1({tag, " FB_WEN"}, FB_WEN, 1'b1);
    chk12({tag, " FB_A"}, FB_A, 12'h000);
    chk12({tag, " FB_D"}, FB_D, 12'h000);
    chk1({tag, " rd_valid"}, rd_valid, 1'b0);
    chk12({tag, " rd_data"}, rd_data, 12'h000);
    chk1({tag, " flush_done"}, flush_done, 1'b0);
    chk1({tag, " wr_ready"}, wr_ready, 1'b1);
    chk1({tag, " fifo_empty"}, fifo_empty, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g_cnt;
    int base;
    int k;
    logic [23:0] ent;
    logic [23:0] exp_ent;
    logic exp_gnt [7];
    logic f_wv [7];
    logic f_fl [7];
    logic f_gnt [7];
    logic f_done [7];

    reset = 1'b0; wr_valid = 1'b0; wr_addr = 12'h000; wr_data = 12'h000;
    rd_req = 1'b0; rd_addr = 12'h000; flush = 1'b0;

    // wv wa wd rr ra fl | gnt cen wen chkad a d emp rdy rv rdata
    tbl[0] = '{1'b1, 12'h010, 12'hABC, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[1] = '{1'b1, 12'h011, 12'hABD, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[2] = '{1'b1, 12'h012, 12'hABE, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h010, 12'hABC, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[3] = '{1'b1, 12'h013, 12'hABF, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h011, 12'hABD, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[4] = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h012, 12'hABE, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[5] = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h013, 12'hABF, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[6] = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h013, 12'hABF, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[7] = '{1'b0, 12'h000, 12'h000, 1'b1, 12'h010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h013, 12'hABF, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[8] = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h010, 12'hABF, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[9] = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h010, 12'hABF, 1'b1, 1'b1, 1'b1, 12'hABC};

    smp();
    chk_reset_vals("reset");
    cyc(); cyc();
    reset = 1'b1;
    smp();
    chk1("post-release FB_CEN", FB_CEN, 1'b1);
    cyc(); cyc();

    // Four posted writes then a read-back, cycle by cycle.
    for (int i = 0; i < 10; i++) begin
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_req = tbl[i].rr; rd_addr = tbl[i].ra; flush = tbl[i].fl;
      smp();
      chk1($sformatf("v%0d rd_gnt", i), rd_gnt, tbl[i].gnt);
      chk1($sformatf("v%0d FB_CEN", i), FB_CEN, tbl[i].cen);
      chk1($sformatf("v%0d FB_WEN", i), FB_WEN, tbl[i].wen);
      chk1($sformatf("v%0d fifo_empty", i), fifo_empty, tbl[i].emp);
      chk1($sformatf("v%0d wr_ready", i), wr_ready, tbl[i].rdy);
      chk1($sformatf("v%0d rd_valid", i), rd_valid, tbl[i].rv);
      if (tbl[i].chkad) begin
        chk12($sformatf("v%0d FB_A", i), FB_A, tbl[i].a);
        chk12($sformatf("v%0d FB_D", i), FB_D, tbl[i].d);
      end
      if (tbl[i].rv) begin
        chk12($sformatf("v%0d rd_data", i), rd_data, tbl[i].rdata);
      end
      cyc();
    end

    // Starvation limit: one write pending behind a continuous read stream.
    exp_gnt = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    g_cnt = 0;
    rd_req = 1'b1; rd_addr = 12'h100;
    for (int i = 0; i < 7; i++) begin
      wr_valid = (i == 0); wr_addr = 12'h0A0; wr_data = 12'h321;
      smp();
      chk1($sformatf("starve c%0d rd_gnt", i), rd_gnt, exp_gnt[i]);
      if (rd_gnt && !fifo_empty) g_cnt++;
      if (i == 5) begin
        chk1("starve write WEN", FB_WEN, 1'b0);
        chk12("starve write A", FB_A, 12'h0A0);
        chk12("starve write D", FB_D, 12'h321);
      end
      cyc();
    end
    chk12("starve grants while pending", 12'(g_cnt), 12'd3);
    rd_req = 1'b0; wr_valid = 1'b0;
    cyc(); cyc(); cyc();

    // Read latency: store 0x5A5, then read it back two cycles after the grant.
    wr_valid = 1'b1; wr_addr = 12'h155; wr_data = 12'h5A5;
    cyc();
    wr_valid = 1'b0;
    cyc(); cyc(); cyc();
    rd_req = 1'b1; rd_addr = 12'h155;
    smp();
    chk1("lat grant", rd_gnt, 1'b1);
    cyc();
    rd_req = 1'b0;
    smp();
    chk1("lat t+1 rd_valid", rd_valid, 1'b0);
    cyc();
    smp();
    chk1("lat t+2 rd_valid", rd_valid, 1'b1);
    chk12("lat t+2 rd_data", rd_data, 12'h5A5);
    cyc(); cyc();

    // Fill the FIFO behind reads, keep pushing while full, check the write stream.
    base = wlog.size();
    rd_req = 1'b1; rd_addr = 12'h3FF;
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1; wr_addr = 12'h200 + 12'(i); wr_data = 12'h800 + 12'(i);
      smp();
      chk1($sformatf("full c%0d rd_gnt", i), rd_gnt, (i < 4));
      chk1($sformatf("full c%0d wr_ready", i), wr_ready, (i < 4));
      cyc();
    end
    wr_valid = 1'b0; rd_req = 1'b0;
    k = 0;
    while (!fifo_empty && k < 20) begin
      cyc();
      k++;
    end
    chk1("full drained", fifo_empty, 1'b1);
    cyc(); cyc();
    chk12("full write count", 12'(wlog.size() - base), 12'd7);
    for (int i = 0; i < 7; i++) begin
      exp_ent = {12'h200 + 12'(i), 12'h800 + 12'(i)};
      ent = (base + i < wlog.size()) ? wlog[base + i] : 24'h000000;
      chk12($sformatf("full w%0d addr", i), ent[23:12], exp_ent[23:12]);
      chk12($sformatf("full w%0d data", i), ent[11:0], exp_ent[11:0]);
    end

    // Read-after-write hazard on a posted address.
    wr_valid = 1'b1; wr_addr = 12'h040; wr_data = 12'h7FF;
    rd_req = 1'b1; rd_addr = 12'h041;
    smp();
    chk1("raw c0 rd_gnt", rd_gnt, 1'b1);
    cyc();
    wr_valid = 1'b0; rd_addr = 12'h040;
    smp();
`ifdef FB_ARB_RAW_CHECK_EN
    chk1("raw c1 rd_gnt", rd_gnt, 1'b0);
    cyc();
    smp();
    chk1("raw c2 rd_gnt", rd_gnt, 1'b1);
    cyc();
    rd_req = 1'b0;
    cyc();
    smp();
    chk1("raw rd_valid", rd_valid, 1'b1);
    chk12("raw rd_data", rd_data, 12'h7FF);
`else
    chk1("raw c1 rd_gnt", rd_gnt, 1'b1);
`endif
    cyc();
    rd_req = 1'b0;
    cyc(); cyc(); cyc();

    // Flush with two pending writes and reads requested throughout.
    f_wv   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    f_fl   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    f_gnt  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    f_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rd_req = 1'b1; rd_addr = 12'h300;
    for (int i = 0; i < 7; i++) begin
      wr_valid = f_wv[i]; wr_addr = 12'h0B0 + 12'(i); wr_data = (i == 0) ? 12'h111 : 12'h222;
      flush = f_fl[i];
      smp();
      chk1($sformatf("flush c%0d rd_gnt", i), rd_gnt, f_gnt[i]);
      chk1($sformatf("flush c%0d flush_done", i), flush_done, f_done[i]);
      if (i == 3 || i == 4) begin
        chk1($sformatf("flush c%0d FB_WEN", i), FB_WEN, 1'b0);
        chk12($sformatf("flush c%0d FB_A", i), FB_A, 12'h0B0 + 12'(i - 3));
        chk12($sformatf("flush c%0d FB_D", i), FB_D, (i == 3) ? 12'h111 : 12'h222);
      end
      cyc();
    end
    flush = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
    cyc(); cyc(); cyc();

    // Reset asserted in the middle of a drain.
    rd_req = 1'b1; rd_addr = 12'h300;
    wr_valid = 1'b1; wr_addr = 12'h0C0; wr_data = 12'h333;
    cyc();
    wr_addr = 12'h0C1; wr_data = 12'h444;
    cyc();
    wr_valid = 1'b0; flush = 1'b1;
    smp();
    chk1("mid-drain entry rd_gnt", rd_gnt, 1'b0);
    cyc();
    reset = 1'b0;
    smp();
    chk_reset_vals("mid-drain reset");
    cyc();
    flush = 1'b0; rd_req = 1'b0;
    reset = 1'b1;
    smp();
    chk1("release c0 FB_CEN", FB_CEN, 1'b1);
    chk1("release c0 fifo_empty", fifo_empty, 1'b1);
    cyc();
    smp();
    chk1("release c1 FB_CEN", FB_CEN, 1'b1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
